// File: rtl/dog_pkg.sv
// Shared constants, FSM encoding and helpers for the DoG peak-detection stage.
package dog_pkg;

  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int ADDR_W = 16;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 17;

  localparam logic [PIX_W-1:0] PEAK_VAL   = 8'hFF;
  localparam logic [PIX_W-1:0] NOPEAK_VAL = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Saturating increment: the peak counter must never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dog_peak_win.sv
// 3-tap window over the incoming pixel stream. The centre pixel is decided
// when its right neighbour arrives, or on flush when no right neighbour follows.
module dog_peak_win #(
  parameter int IMG_W = dog_pkg::IMG_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        beat,
  input  logic [7:0]  pix,
  input  logic [15:0] col,
  input  logic [15:0] addr,
  input  logic        flush,
  input  logic [7:0]  thresh,
  output logic        dec_valid,
  output logic        dec_peak,
  output logic [15:0] dec_addr
);
  import dog_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);

  logic              has_c;
  logic [PIX_W-1:0]  c_pix;
  logic [PIX_W-1:0]  l_pix;
  logic [ADDR_W-1:0] c_col;
  logic [ADDR_W-1:0] c_addr;
  logic              use_left;
  logic              use_right;

  // Peak compare on the current window; neighbours are masked at row edges.
  always_comb begin
    use_left  = (c_col != '0);
    use_right = beat && (c_col != LAST_COL);
    dec_valid = has_c && (beat || flush);
    dec_peak  = (c_pix > thresh) &&
                (!use_left  || (c_pix >= l_pix)) &&
                (!use_right || (c_pix > pix));
    dec_addr  = c_addr;
  end

  // Tracks whether a centre pixel is waiting for its decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      has_c <= 1'b0;
    end else if (clear) begin
      has_c <= 1'b0;
    end else if (beat) begin
      has_c <= 1'b1;
    end else if (flush) begin
      has_c <= 1'b0;
    end
  end

  // Shift the window on every accepted pixel beat.
  always_ff @(posedge clk) begin
    if (beat) begin
      l_pix  <= c_pix;
      c_pix  <= pix;
      c_col  <= col;
      c_addr <= addr;
    end
  end

endmodule

// File: rtl/dog_peak.sv
// Peak detector over a DoG result image: streams the image out of the
// source RAM, finds local horizontal maxima above a threshold and writes a
// binary peak map, counting the peaks found.
module dog_peak #(
  parameter int IMG_W = dog_pkg::IMG_W,
  parameter int IMG_H = dog_pkg::IMG_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  thresh_i,
  output logic        ram_rd_valid_o,
  output logic [15:0] ram_rd_addr_o,
  input  logic        ram_valid_in,
  input  logic [7:0]  ram_data_in,
  output logic        ram_wr_valid_o,
  output logic [15:0] ram_wr_addr_o,
  output logic [7:0]  ram_wr_data_o,
  output logic [16:0] peak_cnt_o,
  output logic        done
);
  import dog_pkg::*;

  localparam int                N         = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N);

  state_t            state;
  state_t            state_nxt;
  logic              start_acc;
  logic              last_rd;
  logic              beat;
  logic              flush;
  logic [PIX_W-1:0]  thresh;
  logic [CNT_W-1:0]  rx_cnt;
  logic [ADDR_W-1:0] rx_col;
  logic [CNT_W-1:0]  wr_cnt;
  logic              dec_valid;
  logic              dec_peak;
  logic [ADDR_W-1:0] dec_addr;

  // Only beats that belong to the current run are accepted; anything
  // arriving in IDLE (e.g. in-flight reads after a reset) is dropped.
  assign beat  = ram_valid_in && ((state == RUN) || (state == DRAIN)) &&
                 (rx_cnt != N_CNT);
  assign flush = (state == DRAIN) && (rx_cnt == N_CNT);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    last_rd   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (ram_rd_addr_o == LAST_ADDR) begin
          last_rd   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_cnt == N_CNT) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read issue: one address per cycle from 0 to N-1 while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_valid_o <= 1'b0;
      ram_rd_addr_o  <= '0;
    end else if (start_acc) begin
      ram_rd_valid_o <= 1'b1;
      ram_rd_addr_o  <= '0;
    end else if (last_rd) begin
      ram_rd_valid_o <= 1'b0;
      ram_rd_addr_o  <= '0;
    end else if (state == RUN) begin
      ram_rd_addr_o  <= ram_rd_addr_o + 1'b1;
    end
  end

  // Threshold latch and receive counters; rx_cnt is the pixel address and
  // rx_col its column within the row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh <= '0;
      rx_cnt <= '0;
      rx_col <= '0;
    end else if (start_acc) begin
      thresh <= thresh_i;
      rx_cnt <= '0;
      rx_col <= '0;
    end else if (beat) begin
      rx_cnt <= rx_cnt + 1'b1;
      rx_col <= (rx_col == LAST_COL) ? '0 : rx_col + 1'b1;
    end
  end

  dog_peak_win #(
    .IMG_W (IMG_W)
  ) u_win (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_acc),
    .beat      (beat),
    .pix       (ram_data_in),
    .col       (rx_col),
    .addr      (rx_cnt[ADDR_W-1:0]),
    .flush     (flush),
    .thresh    (thresh),
    .dec_valid (dec_valid),
    .dec_peak  (dec_peak),
    .dec_addr  (dec_addr)
  );

  // Registered map writes plus write and peak counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_valid_o <= 1'b0;
      ram_wr_addr_o  <= '0;
      ram_wr_data_o  <= '0;
      wr_cnt         <= '0;
      peak_cnt_o     <= '0;
    end else begin
      ram_wr_valid_o <= dec_valid;
      if (start_acc) begin
        wr_cnt     <= '0;
        peak_cnt_o <= '0;
      end else if (dec_valid) begin
        ram_wr_addr_o <= dec_addr;
        ram_wr_data_o <= dec_peak ? PEAK_VAL : NOPEAK_VAL;
        wr_cnt        <= wr_cnt + 1'b1;
        if (dec_peak) begin
          peak_cnt_o <= sat_inc(peak_cnt_o);
        end
      end
    end
  end

endmodule

// File: tb/tb_dog_peak.sv
// Self-checking bench for dog_peak on a reduced image size, with a behavioural
// RAM of configurable latency and a direct peak-map reference model.
module tb_dog_peak;

  localparam int W = 32;
  localparam int H = 16;
  localparam int N = W * H;
  localparam int SINGLE_ADDR = 16'h0123;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  thresh_i = 8'd0;
  logic        ram_rd_valid_o;
  logic [15:0] ram_rd_addr_o;
  logic        ram_valid_in = 1'b0;
  logic [7:0]  ram_data_in = 8'd0;
  logic        ram_wr_valid_o;
  logic [15:0] ram_wr_addr_o;
  logic [7:0]  ram_wr_data_o;
  logic [16:0] peak_cnt_o;
  logic        done;

  dog_peak #(.IMG_W(W), .IMG_H(H)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .thresh_i       (thresh_i),
    .ram_rd_valid_o (ram_rd_valid_o),
    .ram_rd_addr_o  (ram_rd_addr_o),
    .ram_valid_in   (ram_valid_in),
    .ram_data_in    (ram_data_in),
    .ram_wr_valid_o (ram_wr_valid_o),
    .ram_wr_addr_o  (ram_wr_addr_o),
    .ram_wr_data_o  (ram_wr_data_o),
    .peak_cnt_o     (peak_cnt_o),
    .done           (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [N];
  logic [7:0] exp_map [N];
  int         exp_cnt;

  typedef struct { int addr; int due; } req_t;
  req_t rq[$];
  int   lat_mode = 1;
  int   cyc = 0;

  int         wr_hits [N];
  logic [7:0] wr_vals [N];
  int         stream_addr[$];
  logic [7:0] stream_dat[$];
  int         saved_addr[$];
  logic [7:0] saved_dat[$];
  int         done_cnt = 0;
  int         act_cnt = 0;
  int         oob_cnt = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural RAM and output monitor, both on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        ram_valid_in = 1'b1;
        ram_data_in  = img[rq[0].addr];
        void'(rq.pop_front());
      end else begin
        ram_valid_in = 1'b0;
      end
      if (ram_rd_valid_o) begin
        req_t r;
        r.addr = int'(ram_rd_addr_o) % N;
        r.due  = cyc + ((lat_mode == 0) ? int'($urandom_range(4, 1)) : lat_mode);
        rq.push_back(r);
      end
      if (ram_wr_valid_o) begin
        if (int'(ram_wr_addr_o) < N) begin
          wr_hits[ram_wr_addr_o]++;
          wr_vals[ram_wr_addr_o] = ram_wr_data_o;
        end else begin
          oob_cnt++;
        end
        stream_addr.push_back(int'(ram_wr_addr_o));
        stream_dat.push_back(ram_wr_data_o);
      end
      if (done) done_cnt++;
      if (ram_rd_valid_o || ram_wr_valid_o || done) act_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a pixel is a peak if it exceeds the threshold, is not below
  // its left neighbour and is strictly above its right neighbour, with
  // neighbours only inside the same row.
  task automatic build_model(input int th);
    exp_cnt = 0;
    for (int i = 0; i < N; i++) begin
      int  c;
      bit  l_ok, r_ok, pk;
      c    = i % W;
      l_ok = (c == 0)     ? 1'b1 : (img[i] >= img[i-1]);
      r_ok = (c == W - 1) ? 1'b1 : (img[i] >  img[i+1]);
      pk   = (int'(img[i]) > th) && l_ok && r_ok;
      exp_map[i] = pk ? 8'hFF : 8'h00;
      if (pk) exp_cnt++;
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      wr_hits[i] = 0;
      wr_vals[i] = 8'h00;
    end
    stream_addr.delete();
    stream_dat.delete();
    done_cnt = 0;
    oob_cnt  = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int th);
    @(negedge clk);
    start    = 1'b1;
    thresh_i = 8'(th);
    @(negedge clk);
    start    = 1'b0;
    thresh_i = 8'h5A;
  endtask

  task automatic run_case(input string tag, input int th, input int lmode, input bit restart_mid);
    int         bad;
    int         order_bad;
    logic [16:0] pk_at_done;
    lat_mode = lmode;
    clear_logs();
    build_model(th);
    pulse_start(th);
    if (restart_mid) begin
      repeat (100) @(negedge clk);
      pulse_start(250);
    end
    for (int i = 0; i < 5000 && done_cnt == 0; i++) tick();
    check({tag, "_done_seen"}, done_cnt, 1);
    pk_at_done = peak_cnt_o;
    check({tag, "_peak_at_done"}, pk_at_done, exp_cnt);
    repeat (10) tick();
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_peak_hold"}, peak_cnt_o, exp_cnt);
    check({tag, "_writes"}, stream_addr.size(), N);
    bad = oob_cnt;
    for (int a = 0; a < N; a++)
      if (wr_hits[a] != 1 || wr_vals[a] !== exp_map[a]) bad++;
    check({tag, "_map_bad"}, bad, 0);
    order_bad = 0;
    for (int i = 0; i < stream_addr.size(); i++)
      if (stream_addr[i] != i) order_bad++;
    check({tag, "_order_bad"}, order_bad, 0);
  endtask

  task automatic fill_single();
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    img[SINGLE_ADDR] = 8'd200;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_valid"}, ram_rd_valid_o, 0);
    check({tag, "_rd_addr"},  ram_rd_addr_o,  0);
    check({tag, "_wr_valid"}, ram_wr_valid_o, 0);
    check({tag, "_wr_addr"},  ram_wr_addr_o,  0);
    check({tag, "_wr_data"},  ram_wr_data_o,  0);
    check({tag, "_peak_cnt"}, peak_cnt_o,     0);
    check({tag, "_done"},     done,           0);
  endtask

  task automatic run_reset_case();
    bit reached;
    fill_single();
    lat_mode = 2;
    clear_logs();
    pulse_start(10);
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      tick();
      if (ram_rd_valid_o && ram_rd_addr_o == 16'd300) reached = 1'b1;
    end
    check("rst_reached_read300", reached, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    act_cnt = 0;
    repeat (30) tick();
    check("rst_quiet_activity", act_cnt, 0);
    check("rst_no_done", done_cnt, 0);
    rq.delete();
    run_case("rst_rerun", 10, 2, 1'b0);
  endtask

  initial begin
    int diff;
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero image: no pixel exceeds threshold 0.
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    run_case("zero", 0, 1, 1'b0);
    check("zero_cnt_const", peak_cnt_o, 0);

    // Ramp rows: only the last column of each row is a peak.
    for (int i = 0; i < N; i++) img[i] = 8'(i % W);
    run_case("ramp", 0, 1, 1'b0);
    check("ramp_cnt_const", peak_cnt_o, H);
    check("ramp_last_col", wr_vals[2*W + W - 1], 8'hFF);
    check("ramp_mid_col", wr_vals[2*W + 5], 8'h00);

    // Single bright pixel, latency 1 versus 3.
    fill_single();
    run_case("single_l1", 10, 1, 1'b0);
    check("single_hit", wr_vals[SINGLE_ADDR], 8'hFF);
    saved_addr = stream_addr;
    saved_dat  = stream_dat;
    run_case("single_l3", 10, 3, 1'b0);
    check("lat_stream_len", stream_addr.size(), saved_addr.size());
    diff = 0;
    for (int i = 0; i < stream_addr.size() && i < saved_addr.size(); i++)
      if (stream_addr[i] != saved_addr[i] || stream_dat[i] !== saved_dat[i]) diff++;
    check("lat_stream_diff", diff, 0);

    // Start pulsed mid-run must be ignored.
    run_case("restart", 10, 2, 1'b1);

    // Reset in the middle of a run, then a clean rerun.
    run_reset_case();

    // Random images with ties and random RAM latency.
    for (int k = 0; k < 4; k++) begin
      int th;
      for (int i = 0; i < N; i++)
        img[i] = (k < 2) ? 8'($urandom_range(7, 0)) : 8'($urandom_range(255, 0));
      th = (k < 2) ? int'($urandom_range(4, 0)) : int'($urandom_range(200, 0));
      run_case($sformatf("rand%0d", k), th, (k == 3) ? 1 : 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dog_peak.md
DOG_PEAK -- requirements
Module: dog_peak

Interface
REQ-001 Parameter IMG_W, default 256, image width in pixels.
REQ-002 Parameter IMG_H, default 256, image height in pixels; IMG_W*IMG_H SHALL NOT exceed 65536.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle start pulse, typically driven by the DoG stage done.
REQ-006 thresh_i  input  8  peak threshold, sampled when start is accepted.
REQ-007 ram_rd_valid_o  output  1  read enable to the DoG result RAM.
REQ-008 ram_rd_addr_o  output  16  read address.
REQ-009 ram_valid_in  input  1  read data valid; data returns in issue order, latency at least 1 cycle, not fixed.
REQ-010 ram_data_in  input  8  read data (DoG pixel, unsigned).
REQ-011 ram_wr_valid_o  output  1  write enable to the peak-map RAM.
REQ-012 ram_wr_addr_o  output  16  write address.
REQ-013 ram_wr_data_o  output  8  8'hFF for a peak pixel, 8'h00 otherwise.
REQ-014 peak_cnt_o  output  17  number of peaks found in the last run.
REQ-015 done  output  1  one-cycle pulse when the last map write has been issued.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN and FIN; reset state is IDLE.
REQ-017 IDLE->RUN on start: latch thresh_i, clear peak_cnt_o and the read/receive counters.
REQ-018 start SHALL be ignored in RUN, DRAIN and FIN.
REQ-019 RUN: assert ram_rd_valid_o every cycle with addresses 0..N-1 (N=IMG_W*IMG_H), one per cycle, no gaps; enter DRAIN after address N-1 is issued.
REQ-020 Each ram_valid_in beat SHALL be counted by a receive counter giving the pixel's row and column.
REQ-021 A 3-tap window (left, centre, right) SHALL shift on every ram_valid_in beat.
REQ-022 Pixel n SHALL be decided when pixel n+1 arrives; the last pixel SHALL be decided in the cycle after its arrival.
REQ-023 Peak condition: centre > thresh AND (col==0 OR centre >= left) AND (col==IMG_W-1 OR centre > right).
REQ-024 Neighbours SHALL NOT cross a row boundary: column 0 has no left neighbour and column IMG_W-1 has no right neighbour.
REQ-025 Write outputs SHALL be registered; pixel n is written at address n with ram_wr_valid_o high for exactly one cycle, exactly once.
REQ-026 peak_cnt_o SHALL increment by 1 per peak written, never wrap, and hold its value after done until the next accepted start.
REQ-027 DRAIN->FIN once all N writes have been issued; FIN asserts done for one cycle, then returns to IDLE.
REQ-028 Compares are 8-bit unsigned; the counter is 17-bit so that N=65536 fits.

Reset
REQ-029 Asserting rst_n low in any state SHALL force IDLE, discard the window, and zero ram_rd_valid_o, ram_rd_addr_o, ram_wr_valid_o, ram_wr_addr_o, ram_wr_data_o, peak_cnt_o and done.
REQ-030 After reset is released mid-run, no further reads or writes SHALL occur until a new start.

Structure
REQ-031 The shared package dog_pkg SHALL hold IMG_W, IMG_H, ADDR_W=16, PIX_W=8, the FSM state encoding, and the PEAK_VAL=8'hFF and NOPEAK_VAL=8'h00 constants.
REQ-032 One sub-module, dog_peak_win (3-tap shift window, boundary masks and peak compare), SHALL be instantiated; address counters and the FSM stay in dog_peak.

Verification
REQ-033 All-zero image, thresh 0 -> 65536 writes of 8'h00, peak_cnt_o=0, one done pulse.
REQ-034 Each row pixel=column, thresh 0 -> 8'hFF only at addresses r*256+255, peak_cnt_o=256.
REQ-035 All-zero image except addr 0x1234=200, thresh 10 -> single 8'hFF write at 0x1234, peak_cnt_o=1.
REQ-036 Same image as REQ-035 with RAM latency 1 versus 3 cycles -> identical write stream and count.
REQ-037 start pulsed again mid-RUN -> ignored; run completes with the REQ-035 result and exactly one done pulse.
REQ-038 rst_n low at read 30000 -> all outputs 0 within the cycle and no done; a new start then reproduces the REQ-035 result.
